mem_msr_busif: RTL

// - KS10 backplane IO responder for the memory controller's Memory Status

---
 rtl/mem_msr_busif.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_msr_busif.sv
// KS10 backplane IO responder for the memory controller's Memory Status Register.
// Decodes MSR reads, writes and read-modify-writes, strobes msrWRITE and returns MSR data.
module mem_msr_busif #(
  parameter logic [17:0] MSRADDR = 18'o100000,
  parameter logic [3:0]  IOCTL   = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busREQI,
  input  logic [0:35] busADDRI,
  input  logic [0:35] busDATAI,
  input  logic [0:35] regSTAT,
  output logic        busACKO,
  output logic [0:35] busDATAO,
  output logic        msrWRITE,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_ACK   = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  // Handshake: the requester raises busREQI and holds address/data until it
  // sees busACKO for one cycle, then drops busREQI; a new request is only
  // accepted once busREQI has been observed low.

  state_t      state_q, state_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [0:35] data_q, data_d;
  logic        ack_q, ack_d;
  logic        strobe_q, strobe_d;
  logic [0:35] dout_q, dout_d;

  logic flag_rd, flag_wr, flag_io, flag_iobyte, match;

  assign flag_rd     = busADDRI[3];
  assign flag_wr     = busADDRI[5];
  assign flag_io     = busADDRI[10];
  assign flag_iobyte = busADDRI[13];

  assign match = busREQI && flag_io && !flag_iobyte &&
                 (busADDRI[14:17] == IOCTL) && (busADDRI[18:35] == MSRADDR) &&
                 (flag_rd || flag_wr);

  // Write data goes straight to the MSR outside this block; remaining flag bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{busDATAI, busADDRI[0:2], busADDRI[4], busADDRI[6:9], busADDRI[11:12]};

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (match) begin
          rd_d    = flag_rd;
          wr_d    = flag_wr;
          state_d = flag_rd ? ST_READ : ST_WRITE;
        end
      end
      ST_READ: begin
        // Read precedes write so an RMW returns the pre-write MSR value.
        data_d  = regSTAT;
        state_d = wr_q ? ST_WRITE : ST_ACK;
      end
      ST_WRITE: state_d = ST_ACK;
      ST_ACK:   state_d = ST_WAIT;
      ST_WAIT:  if (!busREQI) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are flop outputs aligned with the state.
  always_comb begin
    ack_d    = (state_d == ST_ACK);
    strobe_d = (state_d == ST_WRITE);
    dout_d   = (state_d == ST_ACK && rd_d) ? data_d : 36'd0;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      data_q   <= 36'd0;
      ack_q    <= 1'b0;
      strobe_q <= 1'b0;
      dout_q   <= 36'd0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      strobe_q <= strobe_d;
      dout_q   <= dout_d;
    end
  end

  assign busACKO     = ack_q;
  assign msrWRITE    = strobe_q;
  assign busDATAO    = dout_q;
  assign dbg_state_o = state_q;

endmodule
